// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two valid/ready requesters with a held, registered response
module alu_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_b,
  input  logic [1:0]       req0_ctrl,
  input  logic [1:0]       req1_ctrl,
  output logic             resp0_valid,
  output logic             resp1_valid,
  input  logic             resp0_ready,
  input  logic             resp1_ready,
  output logic [31:0]      resp_result,
  output logic [3:0]       resp_flags,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam bit fp = FIXED_PRIO != 0;
  state_t state;
  logic last_grant;
  logic [31:0] a_q, b_q;
  logic [1:0] ctrl_q;
  logic idle, pick1, resp_hs;
  always_comb begin
    idle = state == IDLE && !reset;
    pick1 = req1_valid && !(req0_valid && (fp || last_grant));
    resp_hs = grant_id ? resp1_ready : resp0_ready;
  end
  assign req0_ready = idle && req0_valid && !pick1;
  assign req1_ready = idle && pick1;
  assign resp0_valid = state == RESP && !reset && !grant_id;
  assign resp1_valid = state == RESP && !reset && grant_id;
  assign busy = state != IDLE;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_ctrl = ctrl_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ctrl_q <= '0;
      resp_result <= '0;
      resp_flags <= '0;
      op_count <= '0;
      grant_id <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          a_q <= pick1 ? req1_a : req0_a;
          b_q <= pick1 ? req1_b : req0_b;
          ctrl_q <= pick1 ? req1_ctrl : req0_ctrl;
          grant_id <= pick1;
          last_grant <= pick1;
          state <= EXEC;
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_flags <= alu_flags;
          state <= RESP;
        end
        RESP: if (resp_hs) begin
          op_count <= op_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + random checks of the round-robin arbiter, with a fixed-priority twin for tie behaviour
module tb_alu_arbiter;
  logic clk = 0, reset = 1;
  logic rv [2], sr [2];
  logic [31:0] ra [2], rb [2];
  logic [1:0] rc [2];
  logic rr0, rr1, sv0, sv1, busy, gid;
  logic [31:0] res, aa, ab, ar;
  logic [3:0] flags, af;
  logic [1:0] ac;
  logic [3:0] cntq;
  logic f_rr0, f_rr1, f_sv0, f_sv1, f_busy, f_gid;
  logic [31:0] f_res, f_a, f_b, f_ar;
  logic [3:0] f_flags, f_af;
  logic [1:0] f_c;
  logic [15:0] f_cnt;
  int n_chk = 0, n_fail = 0, cnt = 0, lastw;

  always #5 clk = ~clk;

  function automatic logic [35:0] alu_f(input logic [31:0] a, b, input logic [1:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic cy, v;
    s = c[0] ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b};
    r = c == 2'd2 ? a & b : c == 2'd3 ? a | b : s[31:0];
    cy = !c[1] && s[32];
    v = !c[1] && ((a[31] ^ b[31]) == c[0]) && (r[31] != a[31]);
    return {r[31], r == 32'd0, cy, v, r};
  endfunction

  assign {af, ar} = alu_f(aa, ab, ac);
  assign {f_af, f_ar} = alu_f(f_a, f_b, f_c);

  alu_arbiter #(.FIXED_PRIO(0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(rv[0]), .req1_valid(rv[1]), .req0_ready(rr0), .req1_ready(rr1),
    .req0_a(ra[0]), .req1_a(ra[1]), .req0_b(rb[0]), .req1_b(rb[1]),
    .req0_ctrl(rc[0]), .req1_ctrl(rc[1]),
    .resp0_valid(sv0), .resp1_valid(sv1), .resp0_ready(sr[0]), .resp1_ready(sr[1]),
    .resp_result(res), .resp_flags(flags),
    .alu_a(aa), .alu_b(ab), .alu_ctrl(ac), .alu_result(ar), .alu_flags(af),
    .busy(busy), .grant_id(gid), .op_count(cntq)
  );

  alu_arbiter #(.FIXED_PRIO(1), .CNT_W(16)) dutf (
    .clk(clk), .reset(reset),
    .req0_valid(rv[0]), .req1_valid(rv[1]), .req0_ready(f_rr0), .req1_ready(f_rr1),
    .req0_a(ra[0]), .req1_a(ra[1]), .req0_b(rb[0]), .req1_b(rb[1]),
    .req0_ctrl(rc[0]), .req1_ctrl(rc[1]),
    .resp0_valid(f_sv0), .resp1_valid(f_sv1), .resp0_ready(sr[0]), .resp1_ready(sr[1]),
    .resp_result(f_res), .resp_flags(f_flags),
    .alu_a(f_a), .alu_b(f_b), .alu_ctrl(f_c), .alu_result(f_ar), .alu_flags(f_af),
    .busy(f_busy), .grant_id(f_gid), .op_count(f_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] o, e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1;
    rv[0] = 0; rv[1] = 0; sr[0] = 0; sr[1] = 0;
    cyc;
    reset = 0;
    cnt = 0;
    lastw = 1;
    #1;
  endtask

  // one full transaction: accept, EXEC, RESP held for bp cycles (optionally with the other side requesting), handshake
  task automatic run_op(input bit w, input logic [31:0] a, b, input logic [1:0] c, input int bp, input bit other);
    logic [35:0] e;
    e = alu_f(a, b, c);
    rv[w] = 1; ra[w] = a; rb[w] = b; rc[w] = c;
    #1;
    chk("ready", {rr1, rr0}, w ? 2'b10 : 2'b01);
    cyc;
    rv[w] = 0; ra[w] = $urandom; rb[w] = $urandom; rc[w] = 2'($urandom);
    #1;
    chk("exec", {busy, sv1, sv0, aa, ab, ac}, {1'b1, 2'b00, a, b, c});
    cyc;
    chk("resp", {sv1, sv0, res, flags}, {w ? 2'b10 : 2'b01, e[31:0], e[35:32]});
    if (other) rv[!w] = 1;
    repeat (bp) begin
      cyc;
      chk("hold", {sv1, sv0, rr1, rr0, busy, res, flags}, {w ? 2'b10 : 2'b01, 2'b00, 1'b1, e[31:0], e[35:32]});
    end
    rv[!w] = 0;
    sr[w] = 1;
    cyc;
    sr[w] = 0;
    cnt = (cnt + 1) % 16;
    #1;
    chk("done", {busy, sv1, sv0, gid, cntq}, {3'b000, w, 4'(cnt)});
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; sr[i] = 0; ra[i] = 0; rb[i] = 0; rc[i] = 0;
    end
    repeat (2) cyc;
    rv[0] = 1; rv[1] = 1;
    #1;
    chk("in_reset", {rr1, rr0, sv1, sv0, busy}, 5'd0);
    do_reset;
    chk("reset_state", {busy, gid, cntq, res, flags, aa, ab}, 0);
    run_op(0, 32'd5, 32'd3, 2'd0, 0, 0);
    run_op(1, 32'h7FFF_FFFF, 32'd1, 2'd0, 0, 0);
    run_op(0, 32'hF0F0, 32'h0FF0, 2'd2, 5, 1);
    run_op(1, 32'd3, 32'd5, 2'd1, 1, 0);
    for (int k = 0; k < 10; k++)
      run_op(1'($urandom), $urandom, $urandom, 2'($urandom), $urandom_range(0, 2), 1'($urandom));
    rv[0] = 1; ra[0] = 32'd9; rb[0] = 32'd9; rc[0] = 2'd0;
    #1;
    cyc;
    rv[0] = 0; rv[1] = 1; reset = 1;
    #1;
    chk("reset_ready", {rr1, rr0, sv1, sv0}, 4'd0);
    cyc;
    reset = 0; rv[1] = 0; cnt = 0; lastw = 1;
    #1;
    chk("after_reset", {busy, sv1, sv0, cntq}, 0);
    cyc;
    chk("no_resp", {busy, sv1, sv0, cntq}, 0);
    rv[0] = 1; rv[1] = 1; sr[0] = 1; sr[1] = 1;
    for (int k = 0; k < 4; k++) begin
      int exp_w;
      exp_w = !lastw;
      #1;
      chk("rr_ready", {rr1, rr0}, exp_w ? 2'b10 : 2'b01);
      chk("fp_ready", {f_rr1, f_rr0}, 2'b01);
      cyc;
      chk("rr_grant", {gid, f_gid}, {1'(exp_w), 1'b0});
      cyc;
      cyc;
      lastw = exp_w;
      cnt++;
    end
    rv[0] = 0; rv[1] = 0; sr[0] = 0; sr[1] = 0;
    #1;
    chk("tie_counts", {cntq, f_cnt}, {4'(cnt), 16'd4});
    do_reset;
    for (int k = 0; k < 17; k++) run_op(1'(k), 32'd0, 32'd0, 2'd3, 0, 0);
    chk("wrap", {cntq, flags}, {4'd1, 4'b0100});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
